// File: rtl/al_pkg.sv
// Shared definitions for the active-list commit controller: control-word bit
// positions and the commit FSM state encoding.
package al_pkg;

   localparam int AL_DONE_BIT  = 0;
   localparam int AL_EXC_BIT   = 1;
   localparam int AL_STORE_BIT = 2;

   typedef enum logic [1:0] {
      AL_RUN     = 2'd0,
      AL_FLUSH   = 2'd1,
      AL_RECOVER = 2'd2
   } al_state_e;

endpackage

// File: rtl/al_retire_sel.sv
// In-order retire select: a prefix chain over the CW head slots that stops at the
// first incomplete, excepting or second-store slot, or at the end of the valid entries.
module al_retire_sel import al_pkg::*; #(
   parameter int INDEX = 4,
   parameter int CW    = 4,
   parameter int WIDTH = 8
) (
   input  logic [INDEX:0]           count_i,
   input  logic [CW*WIDTH-1:0]      ctrl_i,
   input  al_state_e                state_i,
   output logic [CW-1:0]            commit_valid_o,
   output logic [$clog2(CW+1)-1:0]  commit_cnt_o
);

   localparam int CCW = $clog2(CW+1);

   logic ok;
   logic store_seen;
   logic done_k;
   logic exc_k;
   logic store_k;
   logic unused_ctrl;

   // Opaque control-word bits are carried by the RAM but never inspected here.
   assign unused_ctrl = ^ctrl_i;

   always_comb begin
      // NOTE: every variable gets a default before the loop so no latch is inferred.
      ok             = 1'b1;
      store_seen     = 1'b0;
      done_k         = 1'b0;
      exc_k          = 1'b0;
      store_k        = 1'b0;
      commit_valid_o = '0;
      commit_cnt_o   = '0;
      for (int k = 0; k < CW; k++) begin
         done_k  = ctrl_i[k*WIDTH + AL_DONE_BIT];
         exc_k   = ctrl_i[k*WIDTH + AL_EXC_BIT];
         store_k = ctrl_i[k*WIDTH + AL_STORE_BIT];
         ok = ok & ((INDEX+1)'(k) < count_i) & done_k & ~exc_k & ~(store_k & store_seen);
         commit_valid_o[k] = ok;
         if (ok) begin
            store_seen   = store_seen | store_k;
            commit_cnt_o = commit_cnt_o + CCW'(1);
         end
      end
      if (state_i != AL_RUN) begin
         commit_valid_o = '0;
         commit_cnt_o   = '0;
      end
   end

endmodule

// File: rtl/al_commit_ctrl.sv
// Active-list head/tail manager with in-order multi-slot retire and exception flush.
// Optional performance counters are enabled by defining AL_COMMIT_PERF_EN.
module al_commit_ctrl import al_pkg::*; #(
   parameter int DEPTH       = 16,
   parameter int INDEX       = 4,
   parameter int CW          = 4,
   parameter int DW          = 4,
   parameter int WIDTH       = 8,
   parameter int RECOVER_CYC = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      disp_valid_i,
   input  logic [$clog2(DW+1)-1:0]   disp_cnt_i,
   output logic [INDEX-1:0]          al_tail_o,
   output logic [INDEX:0]            al_free_o,
   output logic                      stall_o,
   output logic [CW*INDEX-1:0]       rd_addr_o,
   input  logic [CW*WIDTH-1:0]       rd_data_i,
   output logic [CW-1:0]             commit_valid_o,
   output logic [$clog2(CW+1)-1:0]   commit_cnt_o,
   output logic [INDEX-1:0]          al_head_o,
   output logic                      flush_o,
   output logic [INDEX-1:0]          exc_idx_o
`ifdef AL_COMMIT_PERF_EN
   ,output logic [31:0]              perf_commit_o
   ,output logic [31:0]              perf_stall_o
`endif
);

   localparam int RCW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

   al_state_e         state_q;
   logic [INDEX-1:0]  head_q, head_d;
   logic [INDEX-1:0]  tail_q, tail_d;
   logic [INDEX:0]    count_q, count_d;
   logic [RCW-1:0]    rcnt_q;
   logic              flush_q;
   logic [INDEX-1:0]  exc_idx_q;
   logic              alloc;
   logic              exc_at_head;

   al_retire_sel #(
      .INDEX (INDEX),
      .CW    (CW),
      .WIDTH (WIDTH)
   ) u_retire_sel (
      .count_i        (count_q),
      .ctrl_i         (rd_data_i),
      .state_i        (state_q),
      .commit_valid_o (commit_valid_o),
      .commit_cnt_o   (commit_cnt_o)
   );

   for (genvar k = 0; k < CW; k++) begin : g_rd_addr
      assign rd_addr_o[k*INDEX +: INDEX] = head_q + INDEX'(k);
   end

   assign al_free_o = (INDEX+1)'(DEPTH) - count_q;
   assign stall_o   = (al_free_o < (INDEX+1)'(DW)) | (state_q != AL_RUN);
   assign alloc     = disp_valid_i & ~stall_o;
   assign al_tail_o = tail_q;
   assign al_head_o = head_q;
   assign flush_o   = flush_q;
   assign exc_idx_o = exc_idx_q;

   // Only the oldest entry may trigger recovery; younger exceptions wait their turn.
   assign exc_at_head = (state_q == AL_RUN) && (count_q != '0)
                        && rd_data_i[AL_DONE_BIT] && rd_data_i[AL_EXC_BIT];

   assign head_d  = head_q + INDEX'(commit_cnt_o);
   assign tail_d  = alloc ? tail_q + INDEX'(disp_cnt_i) : tail_q;
   assign count_d = count_q + (alloc ? (INDEX+1)'(disp_cnt_i) : (INDEX+1)'(0))
                    - (INDEX+1)'(commit_cnt_o);

   // NOTE: non-blocking assignments make every register update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= AL_RUN;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         rcnt_q    <= '0;
         flush_q   <= 1'b0;
         exc_idx_q <= '0;
      end else begin
         case (state_q)
            AL_RUN: begin
               if (exc_at_head) begin
                  state_q   <= AL_FLUSH;
                  flush_q   <= 1'b1;
                  exc_idx_q <= head_q;
                  tail_q    <= head_q;
                  count_q   <= '0;
               end else begin
                  head_q  <= head_d;
                  tail_q  <= tail_d;
                  count_q <= count_d;
               end
            end
            AL_FLUSH: begin
               state_q <= AL_RECOVER;
               flush_q <= 1'b0;
               rcnt_q  <= RCW'(RECOVER_CYC - 1);
               tail_q  <= head_q;
               count_q <= '0;
            end
            AL_RECOVER: begin
               if (rcnt_q == '0) begin
                  state_q <= AL_RUN;
               end else begin
                  rcnt_q <= rcnt_q - RCW'(1);
               end
            end
            default: begin
               state_q <= AL_RUN;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef AL_COMMIT_PERF_EN
   logic [31:0] perf_commit_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_commit_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_commit_q <= perf_commit_q + 32'(commit_cnt_o);
         if (disp_valid_i && stall_o) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_commit_o = perf_commit_q;
   assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: doc/al_commit_ctrl.md
Name: al_commit_ctrl

Overview:
- Active-list head/tail manager; sits on the read side of the active-list control RAM.
- Allocates entries at dispatch and drives the per-slot commit read addresses.
- Consumes the control words read back and retires up to CW consecutive completed entries per cycle, in order.
- Detects an exception at head and sequences a flush/recovery.

Parameters:
- DEPTH, 16, active-list entries (power of 2)
- INDEX, 4, log2(DEPTH)
- CW, 4, commit width (1..4)
- DW, 4, dispatch width
- WIDTH, 8, control word width
- RECOVER_CYC, 4, cycles spent in RECOVER after a flush (>=1)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- disp_valid_i  in  1  dispatch group valid
- disp_cnt_i  in  $clog2(DW+1)  entries to allocate this cycle
- al_tail_o  out  INDEX  index of first allocated entry (current tail)
- al_free_o  out  INDEX+1  free entries, DEPTH-count
- stall_o  out  1  dispatch must hold
- rd_addr_o  out  CW*INDEX  slot k address = (head+k) mod DEPTH, to control RAM read ports
- rd_data_i  in  CW*WIDTH  control words (async read); bit0 done, bit1 exception, bit2 is_store, rest opaque
- commit_valid_o  out  CW  per-slot retire strobe, contiguous from bit0
- commit_cnt_o  out  $clog2(CW+1)  popcount of commit_valid_o
- al_head_o  out  INDEX  current head
- flush_o  out  1  one-cycle pipeline flush pulse
- exc_idx_o  out  INDEX  index of the excepting entry, valid with flush_o

Behaviour:
- Reset (async, reset_n=0):
  - head=tail=count=0; state RUN.
  - commit_valid_o=0, flush_o=0, stall_o=0, al_free_o=DEPTH, exc_idx_o=0.
  - Reset mid-flush/recover returns to RUN immediately.
- Pointers: head and tail wrap modulo DEPTH. count is INDEX+1 bits and saturates at neither end; the legal range 0..DEPTH is guaranteed by the stall logic.
- Retire select (combinational from registered head/count and rd_data_i):
  - ok_k = (k < count) & done_k & !exc_k & ok_(k-1), with ok_(-1)=1.
  - Additionally, at most one is_store per cycle: a second store slot and all later slots are blocked.
  - Retirement happens only in RUN; commit_valid_o=ok. Zero-latency strobe; head advances next edge by commit_cnt_o.
- Dispatch:
  - stall_o = (al_free_o < DW) | (state != RUN); registered-count based.
  - Allocation = disp_valid_i & !stall_o; then tail += disp_cnt_i. al_tail_o is the pre-increment tail.
  - Dispatch while stall_o=1 is ignored.
- Simultaneous dispatch and commit: count_next = count + alloc - commit_cnt. Full and empty in the same cycle cannot occur given the stall rule.
- Empty (count=0): no slot is valid regardless of rd_data_i contents.
- Full (count=DEPTH): al_free_o=0, stall_o=1; commit proceeds normally.
- FSM:
  - RUN -> FLUSH when count>0 & done_0 & exc_0. The excepting entry is not retired; slots 0..CW-1 are all blocked that cycle.
  - FLUSH (1 cycle): flush_o=1, exc_idx_o=head, tail<=head, count<=0.
  - FLUSH -> RECOVER: load a down-counter with RECOVER_CYC-1; hold stall_o=1; no commit.
  - RECOVER -> RUN when the counter reaches 0.
- An exception at k>0 is not acted on; older entries retire first, and it is handled once it reaches head.

Optional Feature:
- Macro AL_COMMIT_PERF_EN.
- Defined:
  - Adds outputs perf_commit_o (32 bit): total retired instructions, wraps.
  - Adds outputs perf_stall_o (32 bit): cycles with disp_valid_i & stall_o.
  - Both counters clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package al_pkg:
  - ctrl bit positions AL_DONE_BIT=0, AL_EXC_BIT=1, AL_STORE_BIT=2
  - state enum {AL_RUN, AL_FLUSH, AL_RECOVER}
- Sub-module al_retire_sel: combinational prefix/store-limit chain producing commit_valid and commit_cnt from count, CW control words and state.

Test Plan:
- Reset then dispatch 4, mark all 4 done, no stores -> commit_valid_o=4'b1111, next cycle head=4, al_free_o=16.
- Fill: dispatch 4 per cycle x4 with no completion -> count=16, al_free_o=0, stall_o=1; a 5th dispatch is ignored and tail stays 0.
- Wrap: head=14, count=4, all done -> rd_addr_o={1,0,15,14}, 4 retire, head=2.
- Stores: slots 0..3 done with is_store on slots 1 and 2 -> commit_valid_o=4'b0011, next cycle head+2.
- Exception: slot 0 done+exc at head=5, count=6 -> no retire; next cycle flush_o=1, exc_idx_o=5, tail=5, count=0; stall_o held for RECOVER_CYC cycles after FLUSH, then RUN.
- Reset asserted during RECOVER -> state RUN, stall_o=0, head=tail=0 asynchronously.
